csr_mgr_mq: RTL

CSR_MGR_MQ -- requirements
Module: csr_mgr_mq

---
 rtl/csr_mgr_mq_pkg.sv | 30 +++
 rtl/csr_mgr_mq_if.sv | 28 ++
 rtl/csr_mgr_mq_rsp_fifo.sv | 54 +++++
 rtl/csr_mgr_mq.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/csr_mgr_mq_pkg.sv
// Shared types, CSR index map and DFH builder for the CSR manager.
package csr_mgr_mq_pkg;

   // Wide enough for 32 common CSRs plus up to 224 application CSRs.
   typedef logic [7:0] t_csr_idx;

   localparam t_csr_idx DFH             = 8'd0;
   localparam t_csr_idx AFU_ID_L        = 8'd1;
   localparam t_csr_idx AFU_ID_H        = 8'd2;
   localparam t_csr_idx CTR_RD_RSP      = 8'd8;
   localparam t_csr_idx CTR_WR_RSP      = 8'd9;
   localparam t_csr_idx CTR_ALMFULL     = 8'd10;
   localparam t_csr_idx STATUS          = 8'd11;
   localparam t_csr_idx APP_BASE        = 8'd32;

   localparam logic [3:0] DFH_TYPE_AFU  = 4'h1;

   typedef struct packed {
      logic [8:0]  tid;
      logic [63:0] data;
   } t_rsp_entry;

   // DFH layout: type[63:60], eol[40], nextFeature[39:16], rev[15:12], id[11:0].
   function automatic logic [63:0] build_dfh(input logic [23:0] next_offset);
      logic eol;
      eol = (next_offset == 24'd0);
      return {DFH_TYPE_AFU, 19'd0, eol, next_offset, 4'h0, 12'h000};
   endfunction

endpackage

// File: rtl/csr_mgr_mq_if.sv
// MMIO request, downstream response and merged host response bundle.
interface csr_mgr_mq_if;
   logic        mmio_req_valid;
   logic        mmio_req_is_rd;
   logic [15:0] mmio_req_addr;
   logic [8:0]  mmio_req_tid;
   logic [63:0] mmio_req_data;

   logic        afu_rsp_valid;
   logic [8:0]  afu_rsp_tid;
   logic [63:0] afu_rsp_data;

   logic        host_rsp_valid;
   logic [8:0]  host_rsp_tid;
   logic [63:0] host_rsp_data;

   modport master (
      output mmio_req_valid, mmio_req_is_rd, mmio_req_addr, mmio_req_tid, mmio_req_data,
      output afu_rsp_valid, afu_rsp_tid, afu_rsp_data,
      input  host_rsp_valid, host_rsp_tid, host_rsp_data
   );

   modport slave (
      input  mmio_req_valid, mmio_req_is_rd, mmio_req_addr, mmio_req_tid, mmio_req_data,
      input  afu_rsp_valid, afu_rsp_tid, afu_rsp_data,
      output host_rsp_valid, host_rsp_tid, host_rsp_data
   );
endinterface

// File: rtl/csr_mgr_mq_rsp_fifo.sv
// Show-ahead synchronous FIFO holding local read responses.
module csr_mgr_mq_rsp_fifo
   import csr_mgr_mq_pkg::*;
#(
   parameter int unsigned RSP_FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       push,
   input  t_rsp_entry push_entry,
   input  logic       pop,
   output t_rsp_entry head,
   output logic       full,
   output logic       empty
);
   localparam int unsigned PTR_W = $clog2(RSP_FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   t_rsp_entry       mem [RSP_FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(RSP_FIFO_DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   // A push into a full FIFO is accepted only when a pop frees a slot this cycle.
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_ptr];

   // Entry storage; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_entry;
   end

   // Pointer and occupancy tracking.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/csr_mgr_mq.sv
// CSR manager: DFH/AFU-ID/status/app CSRs with read responses merged into the
// downstream response stream. Optional counters enabled by CSR_MGR_MQ_PERF_CTR_EN.
module csr_mgr_mq
   import csr_mgr_mq_pkg::*;
#(
   parameter int unsigned NUM_APP_CSRS         = 16,
   parameter int unsigned NEXT_DFH_BYTE_OFFSET = 0,
   parameter int unsigned RSP_FIFO_DEPTH       = 4,
   parameter int unsigned CTR_WIDTH            = 48
) (
   input  logic                       clk,
   input  logic                       reset_n,
   csr_mgr_mq_if.slave                bus,
   input  logic [127:0]               afu_id,
   input  logic [64*NUM_APP_CSRS-1:0] app_rd_data,
   output logic [NUM_APP_CSRS-1:0]    app_wr_en,
   output logic [63:0]                app_wr_data,
   input  logic                       rd_rsp_evt,
   input  logic                       wr_rsp_evt,
   input  logic                       almfull_evt,
   input  logic                       err_in,
   output logic                       rsp_overflow
);
   localparam int unsigned NUM_CSRS    = 32 + NUM_APP_CSRS;
   localparam int unsigned IDX_W       = $clog2(NUM_CSRS);
   localparam logic [16:0] LOCAL_LIMIT = 17'(2 * NUM_CSRS);
   localparam logic [63:0] DFH_VALUE   = build_dfh(24'(NEXT_DFH_BYTE_OFFSET));

   t_csr_idx                csr_idx;
   t_csr_idx                app_off;
   logic                    is_local;
   logic                    rd_fire;
   logic                    wr_fire;
   logic [63:0]             rd_word;
   logic [NUM_APP_CSRS-1:0] wr_en_d;
   logic                    rd_valid_q;
   t_rsp_entry              rd_entry_q;
   t_rsp_entry              fifo_head;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic                    fifo_pop;
   logic                    error_raised;
   logic [63:0]             rd_rsp_cnt;
   logic [63:0]             wr_rsp_cnt;
   logic [63:0]             almfull_cnt;

   // Address decode: DWORD address, one CSR per pair of DWORDs.
   always_comb begin
      csr_idx              = '0;
      csr_idx[IDX_W-1:0]   = bus.mmio_req_addr[IDX_W:1];
      is_local             = ({1'b0, bus.mmio_req_addr} < LOCAL_LIMIT);
      app_off              = csr_idx - APP_BASE;
      rd_fire              = bus.mmio_req_valid & bus.mmio_req_is_rd & is_local;
      wr_fire              = bus.mmio_req_valid & ~bus.mmio_req_is_rd & is_local &
                             (csr_idx >= APP_BASE);
   end

`ifdef CSR_MGR_MQ_PERF_CTR_EN
   logic [CTR_WIDTH-1:0] rd_rsp_ctr;
   logic [CTR_WIDTH-1:0] wr_rsp_ctr;
   logic [CTR_WIDTH-1:0] almfull_ctr;

   // Free-running event counters, wrapping at 2^CTR_WIDTH.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_rsp_ctr  <= '0;
         wr_rsp_ctr  <= '0;
         almfull_ctr <= '0;
      end else begin
         if (rd_rsp_evt)  rd_rsp_ctr  <= rd_rsp_ctr + 1'b1;
         if (wr_rsp_evt)  wr_rsp_ctr  <= wr_rsp_ctr + 1'b1;
         if (almfull_evt) almfull_ctr <= almfull_ctr + 1'b1;
      end
   end

   assign rd_rsp_cnt  = 64'(rd_rsp_ctr);
   assign wr_rsp_cnt  = 64'(wr_rsp_ctr);
   assign almfull_cnt = 64'(almfull_ctr);
`else
   logic                 unused_evt;
   logic [CTR_WIDTH-1:0] unused_ctr_width;

   assign unused_evt       = ^{rd_rsp_evt, wr_rsp_evt, almfull_evt};
   assign unused_ctr_width = '0;
   assign rd_rsp_cnt       = '0;
   assign wr_rsp_cnt       = '0;
   assign almfull_cnt      = '0;
`endif

   // Read data mux; unmapped common indices read as zero.
   always_comb begin
      rd_word = '0;
      case (csr_idx)
         DFH:         rd_word = DFH_VALUE;
         AFU_ID_L:    rd_word = afu_id[63:0];
         AFU_ID_H:    rd_word = afu_id[127:64];
         CTR_RD_RSP:  rd_word = rd_rsp_cnt;
         CTR_WR_RSP:  rd_word = wr_rsp_cnt;
         CTR_ALMFULL: rd_word = almfull_cnt;
         STATUS:      rd_word = {61'd0, rsp_overflow, fifo_full, error_raised};
         default: begin
            for (int i = 0; i < int'(NUM_APP_CSRS); i++) begin
               if (csr_idx >= APP_BASE && app_off == t_csr_idx'(i)) begin
                  rd_word = app_rd_data[i*64 +: 64];
               end
            end
         end
      endcase
   end

   // One-hot application write strobe.
   always_comb begin
      wr_en_d = '0;
      for (int i = 0; i < int'(NUM_APP_CSRS); i++) begin
         wr_en_d[i] = wr_fire && (app_off == t_csr_idx'(i));
      end
   end

   // Register read data and tid; the registered entry is pushed the next cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_valid_q <= 1'b0;
         rd_entry_q <= '0;
      end else begin
         rd_valid_q <= rd_fire;
         if (rd_fire) rd_entry_q <= '{tid: bus.mmio_req_tid, data: rd_word};
      end
   end

   // Local responses only drain in cycles the downstream stream leaves idle.
   assign fifo_pop = ~bus.afu_rsp_valid & ~fifo_empty;

   csr_mgr_mq_rsp_fifo #(
      .RSP_FIFO_DEPTH (RSP_FIFO_DEPTH)
   ) u_rsp_fifo (
      .clk        (clk),
      .reset_n    (reset_n),
      .push       (rd_valid_q),
      .push_entry (rd_entry_q),
      .pop        (fifo_pop),
      .head       (fifo_head),
      .full       (fifo_full),
      .empty      (fifo_empty)
   );

   // Registered output mux: downstream responses win, FIFO head fills idle slots.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.host_rsp_valid <= 1'b0;
         bus.host_rsp_tid   <= '0;
         bus.host_rsp_data  <= '0;
      end else if (bus.afu_rsp_valid) begin
         bus.host_rsp_valid <= 1'b1;
         bus.host_rsp_tid   <= bus.afu_rsp_tid;
         bus.host_rsp_data  <= bus.afu_rsp_data;
      end else if (fifo_pop) begin
         bus.host_rsp_valid <= 1'b1;
         bus.host_rsp_tid   <= fifo_head.tid;
         bus.host_rsp_data  <= fifo_head.data;
      end else begin
         bus.host_rsp_valid <= 1'b0;
      end
   end

   // Single-cycle write strobe with data fan-out.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         app_wr_en   <= '0;
         app_wr_data <= '0;
      end else begin
         app_wr_en <= wr_en_d;
         if (wr_fire) app_wr_data <= bus.mmio_req_data;
      end
   end

   // Sticky status flags, cleared only by reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_overflow <= 1'b0;
         error_raised <= 1'b0;
      end else begin
         if (rd_valid_q && fifo_full && !fifo_pop) rsp_overflow <= 1'b1;
         if (err_in) error_raised <= 1'b1;
      end
   end
endmodule
